// File: rtl/fix_pkg.sv
// Shared definitions for the FIX field writer: parser states, protocol
// characters and the bit layout of the per-field header word.
package fix_pkg;

    typedef enum logic [2:0] {
        TAG,
        VALUE,
        HDR,
        SKIP,
        HOLD
    } fix_state_e;

    localparam logic [7:0] SOH_CHAR  = 8'h01;
    localparam logic [7:0] EQ_CHAR   = 8'h3D;
    localparam logic [7:0] ZERO_CHAR = 8'h30;
    localparam logic [7:0] NINE_CHAR = 8'h39;

    localparam int         CHECKSUM_TAG  = 10;
    localparam logic [7:0] MAX_VALUE_LEN = 8'd255;

    // Header word: tag in the upper half, a zero byte, then the value length.
    localparam int HDR_TAG_LSB   = 16;
    localparam int HDR_LEN_LSB   = 0;
    localparam int HDR_LEN_WIDTH = 8;

endpackage

// File: rtl/fix_tag_decoder.sv
// ASCII decimal accumulator: value = value*10 + digit, saturating at all-ones.
// 'seen' records that at least one digit arrived since the last clear.
// Used for the field tag and, when checksum checking is built in, for the
// checksum value.
module fix_tag_decoder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] value,
    output logic             seen,
    output logic             is_digit
);
    import fix_pkg::*;

    logic [WIDTH+3:0] ext;
    logic [WIDTH+3:0] acc;

    // Digit detect and the widened multiply-accumulate (x10 = x8 + x2).
    always_comb begin
        is_digit = (data >= ZERO_CHAR) && (data <= NINE_CHAR);
        ext      = {4'b0000, value};
        acc      = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, data[3:0]};
    end

    // Accumulator register; any carry into the top nibble saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            seen  <= 1'b0;
        end else if (clr) begin
            value <= '0;
            seen  <= 1'b0;
        end else if (en && is_digit) begin
            seen  <= 1'b1;
            value <= (|acc[WIDTH+3:WIDTH]) ? '1 : acc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fix_field_writer.sv
// FIX stream to message RAM writer. Parses tag=value<SOH> fields, stores each
// field through RAM port 0 as packed value words followed by a header word at
// the field's base slot, and hands the message to the port-1 consumer on the
// checksum field (tag 10) with a msg_done / msg_ack handshake.
// Optional build macro: FIX_CHECKSUM_EN enables running-sum checksum checking.
//
// Input handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready depends only on the parser state, never on
// in_valid, and the producer must hold in_data stable while in_valid is high.
module fix_field_writer #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         TAG_WIDTH  = 16,
    parameter logic [7:0] SOH_CHAR   = fix_pkg::SOH_CHAR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] address_0,
    output logic [DATA_WIDTH-1:0] data_0,
    output logic                  cs_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic                  msg_done,
    output logic [ADDR_WIDTH:0]   msg_words,
    input  logic                  msg_ack,
    output logic                  field_err,
    output logic                  overflow,
    output logic                  checksum_err
);
    import fix_pkg::*;

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PW  = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW:0]   DEPTH_X   = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

    fix_state_e state, next_state;

    // Pointers saturate at RAM_DEPTH so msg_words reports at most the depth.
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         base;
    logic [PW-1:0]         ptr_inc;
    logic [PW:0]           val_addr;
    logic [7:0]            len;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [CW-1:0]         bcnt;
    logic [DATA_WIDTH-1:0] pack_word;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  skip_done;
    logic                  skip_on_soh;

    logic                  wr_fire;
    logic [PW:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_word;

    logic                  accept;
    logic                  is_soh;
    logic                  field_begin;
    logic                  skip_entry;
    logic                  tag_is_ten;

    logic [TAG_WIDTH-1:0]  tag_value;
    logic                  tag_seen;
    logic                  tag_is_digit;

    assign accept      = in_valid && in_ready;
    assign is_soh      = (in_data == SOH_CHAR);
    assign field_begin = (next_state == TAG) && (state != TAG);
    assign skip_entry  = (next_state == SKIP) && (state != SKIP);
    assign tag_is_ten  = (tag_value == TAG_WIDTH'(CHECKSUM_TAG));
    assign oe_0        = 1'b0;
    assign msg_words   = (state == HOLD) ? wr_ptr : '0;

    fix_tag_decoder #(
        .WIDTH(TAG_WIDTH)
    ) u_tag (
        .clk      (clk),
        .rst      (rst),
        .clr      (field_begin),
        .en       (accept && (state == TAG)),
        .data     (in_data),
        .value    (tag_value),
        .seen     (tag_seen),
        .is_digit (tag_is_digit)
    );

    // Word packing, header assembly and saturating pointer arithmetic.
    always_comb begin
        ptr_inc   = (wr_ptr == DEPTH_P) ? wr_ptr : wr_ptr + PW'(1);
        val_addr  = {1'b0, wr_ptr} + (PW + 1)'(1);
        pack_word = wbuf | (DATA_WIDTH'(in_data) << {bcnt, 3'b000});
        hdr_word  = '0;
        hdr_word[HDR_TAG_LSB +: TAG_WIDTH]     = tag_value;
        hdr_word[HDR_LEN_LSB +: HDR_LEN_WIDTH] = len;
    end

    // Next-state, ready and write-request decode.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        wr_fire     = 1'b0;
        wr_addr     = '0;
        wr_word     = '0;
        skip_on_soh = 1'b0;
        case (state)
            TAG: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (tag_is_digit) begin
                        next_state = TAG;
                    end else if ((in_data == EQ_CHAR) && tag_seen) begin
                        next_state = VALUE;
                    end else begin
                        next_state  = SKIP;
                        skip_on_soh = is_soh;
                    end
                end
            end
            VALUE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_soh) begin
                        if (len == 8'd0) begin
                            next_state  = SKIP;
                            skip_on_soh = 1'b1;
                        end else begin
                            // Flush a partial word before the header goes out.
                            if (bcnt != '0) begin
                                wr_fire = 1'b1;
                                wr_addr = val_addr;
                                wr_word = wbuf;
                            end
                            next_state = HDR;
                        end
                    end else if (len == MAX_VALUE_LEN) begin
                        next_state = SKIP;
                    end else if (bcnt == LAST_BYTE) begin
                        wr_fire = 1'b1;
                        wr_addr = val_addr;
                        wr_word = pack_word;
                    end
                end
            end
            HDR: begin
                wr_fire    = 1'b1;
                wr_addr    = {1'b0, base};
                wr_word    = hdr_word;
                next_state = tag_is_ten ? HOLD : TAG;
            end
            SKIP: begin
                // When the offending byte was itself the delimiter, the field
                // has already ended: spend one stalled cycle and resume.
                in_ready = !skip_done;
                if (skip_done) begin
                    next_state = TAG;
                end else if (in_valid && is_soh) begin
                    next_state = TAG;
                end
            end
            HOLD: begin
                if (msg_ack) begin
                    next_state = TAG;
                end
            end
            default: begin
                next_state = TAG;
            end
        endcase
    end

    // State, registered RAM write port, pointers, packing buffer and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TAG;
            cs_0      <= 1'b0;
            we_0      <= 1'b0;
            address_0 <= '0;
            data_0    <= '0;
            msg_done  <= 1'b0;
            field_err <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            base      <= '0;
            len       <= '0;
            wbuf      <= '0;
            bcnt      <= '0;
            skip_done <= 1'b0;
        end else begin
            state     <= next_state;
            cs_0      <= 1'b0;
            we_0      <= 1'b0;
            field_err <= skip_entry;
            msg_done  <= (next_state == HOLD) && (state != HOLD);

            if (wr_fire) begin
                if (wr_addr < DEPTH_X) begin
                    cs_0      <= 1'b1;
                    we_0      <= 1'b1;
                    address_0 <= wr_addr[ADDR_WIDTH-1:0];
                    data_0    <= wr_word;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if ((state == VALUE) && wr_fire) begin
                wr_ptr <= ptr_inc;
            end
            if (state == HDR) begin
                wr_ptr <= ptr_inc;
                base   <= ptr_inc;
            end
            if (skip_entry) begin
                wr_ptr <= base;
            end
            if ((state == HOLD) && msg_ack) begin
                wr_ptr   <= '0;
                base     <= '0;
                overflow <= 1'b0;
            end

            if (field_begin) begin
                len  <= '0;
                wbuf <= '0;
                bcnt <= '0;
            end else if ((state == VALUE) && accept) begin
                if (is_soh) begin
                    wbuf <= '0;
                    bcnt <= '0;
                end else if (len != MAX_VALUE_LEN) begin
                    len <= len + 8'd1;
                    if (bcnt == LAST_BYTE) begin
                        wbuf <= '0;
                        bcnt <= '0;
                    end else begin
                        wbuf <= pack_word;
                        bcnt <= bcnt + CW'(1);
                    end
                end
            end

            if (skip_entry) begin
                skip_done <= skip_on_soh;
            end else if (state != SKIP) begin
                skip_done <= 1'b0;
            end
        end
    end

`ifdef FIX_CHECKSUM_EN
    logic [7:0]  sum;
    logic [7:0]  snap;
    logic        at_start;
    logic        csum_en;
    logic        csum_bad;
    logic [15:0] csum_value;
    logic        csum_seen;
    logic        csum_digit;

    assign csum_en = accept && (state == VALUE) && tag_is_ten && !is_soh;

    fix_tag_decoder #(
        .WIDTH(16)
    ) u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (field_begin),
        .en       (csum_en),
        .data     (in_data),
        .value    (csum_value),
        .seen     (csum_seen),
        .is_digit (csum_digit)
    );

    // Running byte sum, per-field snapshot and the tag-10 comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum          <= '0;
            snap         <= '0;
            at_start     <= 1'b1;
            csum_bad     <= 1'b0;
            checksum_err <= 1'b0;
        end else begin
            if (accept) begin
                sum <= sum + in_data;
            end
            if (accept && at_start) begin
                snap <= sum;
            end
            if (field_begin) begin
                at_start <= 1'b1;
            end else if (accept) begin
                at_start <= 1'b0;
            end
            if (field_begin) begin
                csum_bad <= 1'b0;
            end else if (csum_en && !csum_digit) begin
                csum_bad <= 1'b1;
            end
            if ((state == HDR) && tag_is_ten &&
                (csum_bad || !csum_seen || (csum_value != {8'h00, snap}))) begin
                checksum_err <= 1'b1;
            end
            if ((state == HOLD) && msg_ack) begin
                checksum_err <= 1'b0;
                sum          <= '0;
            end
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

endmodule
